// File: rtl/dbg_halt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dbg_halt_ctrl_pkg
//   Shared definitions for the debug halt controller:
//   - state_e          : one-hot sequencer states
//   - DCAUSE_*         : dcause encodings reported to the debug module
//   - halt_cause()     : priority encoder for simultaneous halt sources
// -----------------------------------------------------------------------------
package dbg_halt_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_RUN    = 5'b00001,
    ST_STEP   = 5'b00010,
    ST_FLUSH  = 5'b00100,
    ST_HALTED = 5'b01000,
    ST_RESUME = 5'b10000
  } state_e;

  localparam logic [2:0] DCAUSE_NONE    = 3'd0;
  localparam logic [2:0] DCAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] DCAUSE_TRIGGER = 3'd2;
  localparam logic [2:0] DCAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] DCAUSE_STEP    = 3'd4;

  // Trigger outranks ebreak, which outranks an external haltreq. Step is
  // handled separately because it only applies when no halt event is present.
  function automatic logic [2:0] halt_cause(input logic trig,
                                            input logic ebreak_en,
                                            input logic hreq);
    logic [2:0] cause;
    cause = DCAUSE_NONE;
    if (trig)           cause = DCAUSE_TRIGGER;
    else if (ebreak_en) cause = DCAUSE_EBREAK;
    else if (hreq)      cause = DCAUSE_HALTREQ;
    return cause;
  endfunction

endpackage

// File: rtl/dbg_halt_ctrl.sv
// -----------------------------------------------------------------------------
// dbg_halt_ctrl
//   Debug-mode entry/exit sequencer. Merges halt sources by priority, drains
//   the pipeline, captures dpc/dcause, holds the core halted until the debug
//   module resumes it, then redirects fetch to dpc.
//
// Ports
//   cpu_clk, cpu_rstn       clock, synchronous active-low reset
//   haltreq, resumereq      debug module requests (levels)
//   trig_bkpt               trigger hit with debug-mode action
//   ebreak_ex, dcsr_ebreakm ebreak in EX and its debug-mode enable
//   dcsr_step               single-step enable, sampled when resuming
//   pc_ex                   pc of instruction in EX
//   instr_retire, pc_next   retirement strobe and following pc (step mode)
//   pipe_empty              nothing in flight after EX
//   dbg_mode, halted        debug mode / halted status
//   resumeack, redirect_vld one-cycle pulses on resume
//   stall_fetch, flush_pipe fetch hold / one-cycle pipeline kill
//   dpc, dcause             captured debug pc and halt cause
// -----------------------------------------------------------------------------
module dbg_halt_ctrl
  import dbg_halt_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  haltreq,
  input  logic                  resumereq,
  input  logic                  trig_bkpt,
  input  logic                  ebreak_ex,
  input  logic                  dcsr_ebreakm,
  input  logic                  dcsr_step,
  input  logic [ADDR_WIDTH-1:0] pc_ex,
  input  logic                  instr_retire,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  pipe_empty,
  output logic                  dbg_mode,
  output logic                  halted,
  output logic                  resumeack,
  output logic                  stall_fetch,
  output logic                  flush_pipe,
  output logic [ADDR_WIDTH-1:0] dpc,
  output logic [2:0]            dcause,
  output logic                  redirect_vld
);

  // The counter saturates at DRAIN_CYCLES rather than DRAIN_CYCLES-1 so that
  // it never returns to zero inside FLUSH; zero then uniquely marks the
  // first FLUSH cycle, which is when flush_pipe fires.
  localparam int              CNT_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_EXIT = CNT_W'(DRAIN_CYCLES - 1);

  state_e                state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [ADDR_WIDTH-1:0] dpc_q,    dpc_d;
  logic [2:0]            dcause_q, dcause_d;
  logic                  halt_evt;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      dpc_q    <= '0;
      dcause_q <= DCAUSE_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dpc_q    <= dpc_d;
      dcause_q <= dcause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dpc_d        = dpc_q;
    dcause_d     = dcause_q;
    dbg_mode     = 1'b0;
    halted       = 1'b0;
    resumeack    = 1'b0;
    stall_fetch  = 1'b0;
    flush_pipe   = 1'b0;
    redirect_vld = 1'b0;
    halt_evt     = trig_bkpt | (ebreak_ex & dcsr_ebreakm) | haltreq;

    unique case (state_q)
      ST_RUN, ST_STEP: begin
        // A halt event stops the instruction in EX before it executes, so
        // it is the one to re-execute on resume.
        if (halt_evt) begin
          state_d  = ST_FLUSH;
          cnt_d    = '0;
          dpc_d    = pc_ex;
          dcause_d = halt_cause(trig_bkpt, ebreak_ex & dcsr_ebreakm, haltreq);
        end else if ((state_q == ST_STEP) && instr_retire) begin
          state_d  = ST_FLUSH;
          cnt_d    = '0;
          dpc_d    = pc_next;
          dcause_d = DCAUSE_STEP;
        end
      end
      ST_FLUSH: begin
        dbg_mode    = 1'b1;
        stall_fetch = 1'b1;
        flush_pipe  = (cnt_q == '0);
        if (pipe_empty && (cnt_q >= CNT_EXIT)) begin
          state_d = ST_HALTED;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HALTED: begin
        dbg_mode    = 1'b1;
        halted      = 1'b1;
        stall_fetch = 1'b1;
        if (resumereq) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        dbg_mode     = 1'b1;
        resumeack    = 1'b1;
        redirect_vld = 1'b1;
        state_d      = dcsr_step ? ST_STEP : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign dpc    = dpc_q;
  assign dcause = dcause_q;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
module tb_dbg_halt_ctrl;

  localparam int AW    = 32;
  localparam int DRAIN = 3;

  logic          clk = 1'b0;
  logic          rstn, haltreq, resumereq, trig_bkpt, ebreak_ex, ebreakm, dstep;
  logic [AW-1:0] pc_ex, pc_next;
  logic          retire, pipe_empty;
  logic          dbg_mode, halted, resumeack, stall_fetch, flush_pipe, redirect_vld;
  logic [AW-1:0] dpc;
  logic [2:0]    dcause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbg_halt_ctrl #(.ADDR_WIDTH(AW), .DRAIN_CYCLES(DRAIN)) dut (
    .cpu_clk(clk), .cpu_rstn(rstn), .haltreq(haltreq), .resumereq(resumereq),
    .trig_bkpt(trig_bkpt), .ebreak_ex(ebreak_ex), .dcsr_ebreakm(ebreakm),
    .dcsr_step(dstep), .pc_ex(pc_ex), .instr_retire(retire), .pc_next(pc_next),
    .pipe_empty(pipe_empty), .dbg_mode(dbg_mode), .halted(halted),
    .resumeack(resumeack), .stall_fetch(stall_fetch), .flush_pipe(flush_pipe),
    .dpc(dpc), .dcause(dcause), .redirect_vld(redirect_vld)
  );

  // Reference model: tracks how long the core has been draining, whether it
  // sits halted, is in its resume cycle, or is armed to stop after one retire.
  int          m_flush_age;   // -1 when not draining, else cycles spent draining
  bit          m_halted, m_resuming, m_stepping;
  logic [AW-1:0] m_dpc;
  logic [2:0]  m_cause;

  task automatic model_reset();
    m_flush_age = -1; m_halted = 0; m_resuming = 0; m_stepping = 0;
    m_dpc = '0; m_cause = 3'd0;
  endtask

  task automatic model_edge();
    bit ev;
    if (!rstn) begin
      model_reset();
    end else if (m_resuming) begin
      m_resuming = 0;
      m_stepping = dstep;
    end else if (m_halted) begin
      if (resumereq) begin m_halted = 0; m_resuming = 1; end
    end else if (m_flush_age >= 0) begin
      if (pipe_empty && m_flush_age >= DRAIN - 1) begin
        m_flush_age = -1; m_halted = 1;
      end else begin
        m_flush_age++;
      end
    end else begin
      ev = trig_bkpt || (ebreak_ex && ebreakm) || haltreq;
      if (ev) begin
        m_cause = trig_bkpt ? 3'd2 : ((ebreak_ex && ebreakm) ? 3'd1 : 3'd3);
        m_dpc = pc_ex; m_flush_age = 0; m_stepping = 0;
      end else if (m_stepping && retire) begin
        m_cause = 3'd4; m_dpc = pc_next; m_flush_age = 0; m_stepping = 0;
      end
    end
  endtask

  function automatic logic [40:0] model_outs();
    bit draining;
    draining = (m_flush_age >= 0);
    return {draining || m_halted || m_resuming, m_halted, m_resuming,
            draining || m_halted, m_flush_age == 0, m_resuming, m_cause, m_dpc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model and DUT advance on the same edge, outputs compared 1ns later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle_outs",
        {23'd0, dbg_mode, halted, resumeack, stall_fetch, flush_pipe, redirect_vld, dcause, dpc},
        {23'd0, model_outs()});
  endtask

  task automatic clear_inputs();
    haltreq = 0; resumereq = 0; trig_bkpt = 0; ebreak_ex = 0; ebreakm = 0;
    dstep = 0; pc_ex = '0; retire = 0; pc_next = '0; pipe_empty = 1; rstn = 1;
  endtask

  task automatic drain();
    pipe_empty = 1;
    repeat (DRAIN) cyc();
  endtask

  task automatic do_resume(input logic step);
    resumereq = 1; dstep = step;
    cyc();
    chk("resume_ack", {resumeack, redirect_vld, dbg_mode, halted}, 4'b1110);
    resumereq = 0;
    cyc();
    chk("post_resume_dbg", dbg_mode, 1'b0);
  endtask

  initial begin
    model_reset();
    clear_inputs();
    rstn = 0;
    repeat (2) cyc();
    rstn = 1;
    chk("reset_outs", {dbg_mode, halted, resumeack, stall_fetch, flush_pipe, redirect_vld, dcause, dpc}, 41'd0);

    // T1: trigger breakpoint at 0x100
    pc_ex = 32'h100; trig_bkpt = 1;
    cyc();
    trig_bkpt = 0;
    chk("t1_flush_pulse", {flush_pipe, stall_fetch, dbg_mode}, 3'b111);
    cyc();
    chk("t1_flush_once", flush_pipe, 1'b0);
    cyc();
    chk("t1_not_yet_halted", halted, 1'b0);
    cyc();
    chk("t1_halted", halted, 1'b1);
    chk("t1_dpc", dpc, 64'h100);
    chk("t1_dcause", dcause, 3'd2);
    do_resume(1'b0);

    // T2: ebreak gated by ebreakm
    pc_ex = 32'h200; ebreak_ex = 1; ebreakm = 0;
    cyc();
    chk("t2_ebreak_ignored", {dbg_mode, stall_fetch, flush_pipe}, 3'b000);
    ebreakm = 1;
    cyc();
    ebreak_ex = 0;
    chk("t2_ebreak_flush", flush_pipe, 1'b1);
    drain();
    chk("t2_halted", halted, 1'b1);
    chk("t2_dcause", dcause, 3'd1);
    chk("t2_dpc", dpc, 64'h200);

    // T4: haltreq while halted is ignored; haltreq+resumereq resumes then re-halts
    haltreq = 1; pc_ex = 32'h250;
    cyc();
    chk("t4_halt_ignored", {halted, dcause}, {1'b1, 3'd1});
    chk("t4_dpc_held", dpc, 64'h200);
    resumereq = 1;
    cyc();
    chk("t4_resumeack", {resumeack, redirect_vld}, 2'b11);
    resumereq = 0;
    cyc();
    chk("t4_run_dbg", dbg_mode, 1'b0);
    cyc();
    haltreq = 0;
    chk("t4_rehalt_flush", flush_pipe, 1'b1);
    chk("t4_rehalt_cause", dcause, 3'd3);
    drain();
    chk("t4_rehalted", halted, 1'b1);
    do_resume(1'b0);

    // T3: all sources together, pipeline slow to drain
    pc_ex = 32'h300; trig_bkpt = 1; ebreak_ex = 1; ebreakm = 1; haltreq = 1; pipe_empty = 0;
    cyc();
    trig_bkpt = 0; ebreak_ex = 0; haltreq = 0;
    chk("t3_cause_prio", dcause, 3'd2);
    repeat (5) cyc();
    chk("t3_held_by_pipe", {halted, stall_fetch}, 2'b01);
    pipe_empty = 1;
    cyc();
    chk("t3_halted", halted, 1'b1);
    chk("t3_dpc", dpc, 64'h300);

    // T5: single step, then step with coincident trigger
    do_resume(1'b1);
    chk("t5_step_running", stall_fetch, 1'b0);
    retire = 1; pc_next = 32'h204; pc_ex = 32'h200;
    cyc();
    retire = 0;
    drain();
    chk("t5_step_halted", halted, 1'b1);
    chk("t5_step_dpc", dpc, 64'h204);
    chk("t5_step_cause", dcause, 3'd4);
    do_resume(1'b1);
    retire = 1; pc_next = 32'h404; pc_ex = 32'h400; trig_bkpt = 1;
    cyc();
    retire = 0; trig_bkpt = 0;
    drain();
    chk("t5_trig_cause", dcause, 3'd2);
    chk("t5_trig_dpc", dpc, 64'h400);
    do_resume(1'b0);

    // T6: reset during FLUSH and during HALTED
    pc_ex = 32'h500; trig_bkpt = 1;
    cyc();
    trig_bkpt = 0;
    rstn = 0;
    cyc();
    rstn = 1;
    chk("t6_reset_in_flush", {dbg_mode, halted, resumeack, stall_fetch, flush_pipe, redirect_vld, dcause, dpc}, 41'd0);
    haltreq = 1; pc_ex = 32'h600;
    cyc();
    haltreq = 0;
    drain();
    chk("t6_halted_again", halted, 1'b1);
    rstn = 0;
    cyc();
    rstn = 1;
    chk("t6_reset_in_halted", {dbg_mode, halted, resumeack, stall_fetch, flush_pipe, redirect_vld, dcause, dpc}, 41'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rstn       = ($urandom_range(0, 299) != 0);
      haltreq    = ($urandom_range(0, 15) == 0);
      resumereq  = ($urandom_range(0, 3) == 0);
      trig_bkpt  = ($urandom_range(0, 23) == 0);
      ebreak_ex  = ($urandom_range(0, 11) == 0);
      ebreakm    = $urandom_range(0, 1);
      dstep      = ($urandom_range(0, 2) == 0);
      retire     = $urandom_range(0, 1);
      pipe_empty = ($urandom_range(0, 3) != 0);
      pc_ex      = $urandom;
      pc_next    = $urandom;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
